// File: rtl/pic_return_stack.sv
// Parametrised return-address stack for the midrange core: CALL/interrupt pushes,
// RETURN/RETLW/RETFIE pops, with selectable wrap or saturate behaviour on faults.
module pic_return_stack #(
  parameter int WIDTH     = 13,
  parameter int DEPTH     = 8,
  parameter int WRAP_MODE = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       clr_flags,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam bit WRAP = (WRAP_MODE != 0);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    sp;
  logic [AW-1:0]    sp_m1;
  logic [AW-1:0]    sp_next;
  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  logic [CW-1:0]    count_next;
  logic             ovf_set;
  logic             unf_set;

  assign sp_m1 = sp - AW'(1);
  assign top   = mem[sp_m1];
  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = sp;
    sp_next    = sp;
    count_next = count;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    if (push && pop && !empty) begin
      // Simultaneous push+pop replaces the top entry in place.
      wr_en   = 1'b1;
      wr_addr = sp_m1;
    end else if (push) begin
      if (!full) begin
        wr_en      = 1'b1;
        sp_next    = sp + AW'(1);
        count_next = count + CW'(1);
      end else begin
        ovf_set = 1'b1;
        if (WRAP) begin
          wr_en   = 1'b1;
          sp_next = sp + AW'(1);
        end
      end
    end else if (pop) begin
      if (!empty) begin
        sp_next    = sp_m1;
        count_next = count - CW'(1);
      end else begin
        unf_set = 1'b1;
        if (WRAP) begin
          sp_next = sp_m1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wr_addr] <= push_data;
      end
      sp    <= sp_next;
      count <= count_next;
      // A fault in the same cycle as clr_flags keeps the flag set.
      overflow  <= ovf_set | (overflow & ~clr_flags);
      underflow <= unf_set | (underflow & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_pic_return_stack.sv
// Bench for pic_return_stack: a saturating and a wrapping instance share stimulus
// and are compared each cycle against an array-based stack model.
module tb_pic_return_stack;

  localparam int W = 13;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] push_data = '0;
  logic         clr_flags = 1'b0;

  logic [W-1:0] top_s, top_w;
  logic [3:0]   count_s, count_w;
  logic         empty_s, empty_w, full_s, full_w;
  logic         overflow_s, overflow_w, underflow_s, underflow_w;

  int checks = 0;
  int errors = 0;

  // Reference model, index 0 = saturating, 1 = wrapping.
  int mmem [2][D];
  int msp  [2];
  int mcnt [2];
  bit mov  [2];
  bit mun  [2];

  always #5 clk = ~clk;

  pic_return_stack #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(0)) dut_sat (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .top(top_s), .count(count_s), .empty(empty_s),
    .full(full_s), .overflow(overflow_s), .underflow(underflow_s)
  );

  pic_return_stack #(.WIDTH(W), .DEPTH(D), .WRAP_MODE(1)) dut_wrap (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .clr_flags(clr_flags), .top(top_w), .count(count_w), .empty(empty_w),
    .full(full_w), .overflow(overflow_w), .underflow(underflow_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int m, input bit rn, input bit pu, input bit po,
                            input int d, input bit clr);
    bit ov, un;
    ov = 1'b0;
    un = 1'b0;
    if (!rn) begin
      for (int i = 0; i < D; i++) mmem[m][i] = 0;
      msp[m] = 0; mcnt[m] = 0; mov[m] = 1'b0; mun[m] = 1'b0;
      return;
    end
    if (pu && po && mcnt[m] > 0) begin
      mmem[m][(msp[m] + D - 1) % D] = d;
    end else if (pu) begin
      if (mcnt[m] < D) begin
        mmem[m][msp[m]] = d;
        msp[m] = (msp[m] + 1) % D;
        mcnt[m] = mcnt[m] + 1;
      end else begin
        ov = 1'b1;
        if (m == 1) begin
          mmem[m][msp[m]] = d;
          msp[m] = (msp[m] + 1) % D;
        end
      end
    end else if (po) begin
      if (mcnt[m] > 0) begin
        msp[m] = (msp[m] + D - 1) % D;
        mcnt[m] = mcnt[m] - 1;
      end else begin
        un = 1'b1;
        if (m == 1) msp[m] = (msp[m] + D - 1) % D;
      end
    end
    mov[m] = ov || (mov[m] && !clr);
    mun[m] = un || (mun[m] && !clr);
  endtask

  task automatic compare_model(input int m, input logic [W-1:0] t, input logic [3:0] c,
                               input logic e, input logic f, input logic o, input logic u);
    string p;
    p = (m == 0) ? "sat" : "wrap";
    check({p, ".top"},       32'(t), 32'(mmem[m][(msp[m] + D - 1) % D]));
    check({p, ".count"},     32'(c), 32'(mcnt[m]));
    check({p, ".empty"},     32'(e), 32'(mcnt[m] == 0));
    check({p, ".full"},      32'(f), 32'(mcnt[m] == D));
    check({p, ".overflow"},  32'(o), 32'(mov[m]));
    check({p, ".underflow"}, 32'(u), 32'(mun[m]));
  endtask

  // One clock: drive at negedge, update model at posedge, sample 1ns later.
  task automatic step(input bit rn, input bit pu, input bit po, input int d, input bit clr);
    @(negedge clk);
    rst = rn; push = pu; pop = po; push_data = W'(d); clr_flags = clr;
    @(posedge clk);
    model_step(0, rn, pu, po, d, clr);
    model_step(1, rn, pu, po, d, clr);
    #1;
    compare_model(0, top_s, count_s, empty_s, full_s, overflow_s, underflow_s);
    compare_model(1, top_w, count_w, empty_w, full_w, overflow_w, underflow_w);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    int r;
    bit pu, po;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < D; i++) mmem[m][i] = 0;
      msp[m] = 0; mcnt[m] = 0; mov[m] = 1'b0; mun[m] = 1'b0;
    end

    // Reset then LIFO
    do_reset();
    check("reset.top", 32'(top_w), 32'h0);
    check("reset.empty", 32'(empty_w), 32'h1);
    check("reset.full", 32'(full_w), 32'h0);
    step(1'b1, 1'b1, 1'b0, 'h0100, 1'b0);
    step(1'b1, 1'b1, 1'b0, 'h0200, 1'b0);
    step(1'b1, 1'b1, 1'b0, 'h0300, 1'b0);
    check("lifo.top3", 32'(top_s), 32'h0300);
    check("lifo.count3", 32'(count_s), 32'd3);
    step(1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("lifo.pop1", 32'(top_s), 32'h0200);
    step(1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("lifo.pop2", 32'(top_s), 32'h0100);
    step(1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("lifo.empty", 32'(empty_s), 32'h1);
    check("lifo.count0", 32'(count_s), 32'd0);
    check("lifo.noflags", 32'({overflow_s, underflow_s, overflow_w, underflow_w}), 32'h0);

    // Overflow: wrap and saturate side by side
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 1'b0, i, 1'b0);
    check("wrap.top9", 32'(top_w), 32'd9);
    check("wrap.count8", 32'(count_w), 32'd8);
    check("wrap.full", 32'(full_w), 32'h1);
    check("wrap.ovf", 32'(overflow_w), 32'h1);
    check("sat.top8", 32'(top_s), 32'd8);
    check("sat.count8", 32'(count_s), 32'd8);
    check("sat.ovf", 32'(overflow_s), 32'h1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 0, 1'b0);
      if (i < 7) check("wrap.poptop", 32'(top_w), 32'(8 - i));
    end
    check("wrap.empty", 32'(empty_w), 32'h1);
    step(1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("wrap.unf", 32'(underflow_w), 32'h1);
    check("wrap.unf_count", 32'(count_w), 32'd0);
    check("wrap.unf_top", 32'(top_w), 32'd8);
    check("sat.unf", 32'(underflow_s), 32'h1);
    check("sat.unf_count", 32'(count_s), 32'd0);
    check("sat.unf_top", 32'(top_s), 32'd8);

    // Simultaneous push+pop
    do_reset();
    step(1'b1, 1'b1, 1'b0, 'h10, 1'b0);
    step(1'b1, 1'b1, 1'b0, 'h20, 1'b0);
    step(1'b1, 1'b1, 1'b1, 'h55, 1'b0);
    check("pp.top", 32'(top_s), 32'h55);
    check("pp.count", 32'(count_s), 32'd2);
    check("pp.flags", 32'({overflow_s, underflow_s}), 32'h0);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 'h55, 1'b0);
    check("pp_empty.top", 32'(top_w), 32'h55);
    check("pp_empty.count", 32'(count_w), 32'd1);
    check("pp_empty.unf", 32'(underflow_w), 32'h0);

    // Flag priority: set beats clear
    do_reset();
    for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 1'b0, i, 1'b0);
    step(1'b1, 1'b1, 1'b0, 'h77, 1'b1);
    check("prio.ovf_held", 32'(overflow_w), 32'h1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    check("prio.ovf_clr", 32'(overflow_w), 32'h0);

    // Reset wins over a push in the same cycle
    do_reset();
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b0, 'h100 * i, 1'b0);
    step(1'b0, 1'b1, 1'b0, 'h1ABC, 1'b0);
    check("rstmid.count", 32'(count_w), 32'd0);
    check("rstmid.top", 32'(top_w), 32'h0);
    check("rstmid.empty", 32'(empty_w), 32'h1);

    // Randomized traffic with phases biased toward filling and draining
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if ((n / 100) % 2 == 0) begin
        pu = (r < 65); po = (r >= 50);
      end else begin
        pu = (r < 35); po = (r >= 20);
      end
      step(($urandom_range(0, 199) != 0), pu, po, $urandom_range(0, (1 << W) - 1),
           ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pic_return_stack.md
Name: pic_return_stack

Overview:
- Parametrised hardware return-address stack for the midrange core family. CALL/interrupt entry pushes the return PC; RETURN/RETLW/RETFIE pops it.
- Generalises the fixed 8-level x 13-bit PIC stack in three ways: depth and width are parameters, overflow/underflow handling is selectable, and sticky fault flags are provided.
- Sits beside program_counter. The instruction decoder drives push/pop, and program_counter loads from top on a return.

Parameters:
- WIDTH, 13: width of one stored return address (matches PC width).
- DEPTH, 8: number of stack entries. Must be a power of two and at least 2.
- WRAP_MODE, 1: 1 = classic PIC circular behaviour (silent overwrite/wrap, flags still set). 0 = saturating (faulting operation ignored, flag set).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-low reset, sampled on rising clk.
- push  input  1  push push_data this cycle.
- pop  input  1  pop top entry this cycle.
- push_data  input  WIDTH  return address to store.
- clr_flags  input  1  clear sticky overflow/underflow.
- top  output  WIDTH  current top-of-stack entry, mem[(sp-1) mod DEPTH].
- count  output  CW  valid entries, 0..DEPTH, where CW = $clog2(DEPTH+1).
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- overflow  output  1  sticky; set on push while full.
- underflow  output  1  sticky; set on pop while empty.

Behaviour:
- State:
  - mem[DEPTH] of WIDTH bits.
  - Write pointer sp, log2(DEPTH) bits, wraps modulo DEPTH.
  - count register; overflow and underflow registers.
- Outputs:
  - top is a combinational read of mem at sp-1 (mod DEPTH).
  - empty and full are combinational from count.
  - Every change is visible the cycle after the clk edge that performs it.
- Reset (rst==0 at a clk edge):
  - sp=0, count=0, all mem entries=0, overflow=0, underflow=0.
  - Reset overrides push/pop/clr_flags in the same cycle and aborts any sequence in progress.
  - Resulting outputs: top=0, empty=1, full=0.
- Push only (push=1, pop=0):
  - Not full: mem[sp]<=push_data, sp<=sp+1, count<=count+1.
  - Full, WRAP_MODE=1: mem[sp]<=push_data (overwrites the oldest entry), sp<=sp+1, count stays DEPTH, overflow<=1.
  - Full, WRAP_MODE=0: no change to mem/sp/count, overflow<=1.
- Pop only (push=0, pop=1):
  - Not empty: sp<=sp-1, count<=count-1. mem is untouched; popped data is not erased.
  - Empty, WRAP_MODE=1: sp<=sp-1 (wraps DEPTH-1 at 0), count stays 0, underflow<=1.
  - Empty, WRAP_MODE=0: no change, underflow<=1.
- Push and pop together:
  - Not empty: replace top. mem[sp-1]<=push_data; sp and count unchanged; no flags set.
  - Empty: behaves exactly as push only; no underflow.
- clr_flags=1 clears both sticky flags. If an overflow or underflow event occurs in the same cycle, the set wins.
- No operation (push=0, pop=0): all state holds.
- Latency: push-to-top is one cycle, pop-to-new-top is one cycle. Back-to-back operations every cycle are supported with no bubbles.
- Arithmetic:
  - sp increment/decrement is pure modulo-DEPTH (natural log2(DEPTH)-bit wrap).
  - count never exceeds DEPTH and never goes below 0.

Test Plan:
- Reset then LIFO: hold rst=0 two cycles, release. Push 0x0100, 0x0200, 0x0300.
  -> top=0x0300, count=3.
  -> Three pops give top 0x0200, 0x0100, then empty=1, count=0. No flags set.
- Wrap overflow (WRAP_MODE=1, DEPTH=8): push 1..9.
  -> After push 9: top=9, count=8, full=1, overflow=1.
  -> Eight pops show tops 8,7,6,5,4,3,2, then empty=1.
  -> A 9th pop sets underflow=1 with count=0, and top then reads 8.
- Saturate (WRAP_MODE=0, DEPTH=8): push 1..9.
  -> top=8, count=8, overflow=1.
  -> Pop on empty after eight pops: count stays 0, underflow=1, top unchanged.
- Simultaneous push+pop: stack [0x10,0x20], push+pop with 0x55.
  -> top=0x55, count=2, no flags.
  -> Same stimulus on an empty stack gives top=0x55, count=1, underflow=0.
- Flag priority: overflow=1, stack full, WRAP_MODE=1. Assert clr_flags and push together.
  -> overflow stays 1.
  -> clr_flags alone next cycle clears it to 0.
- Reset mid-operation: three entries, push asserted in the same cycle as rst=0.
  -> Next cycle count=0, top=0, empty=1, flags 0. The push is discarded.
